m_disp_scan: RTL and testbench

M_DISP_SCAN -- requirements
Module: m_disp_scan

---
 rtl/m_disp_scan.sv | 142 ++++++++++++++
 tb/tb_m_disp_scan.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module   : m_disp_scan
//  Purpose  : Six-digit multiplexed 7-segment scanner with per-frame snapshot,
//             blink and hour leading-zero suppression.
//  Revision : 1.0  initial release
// ============================================================================
module m_disp_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hour_high,
    input  logic [3:0] hour_low,
    input  logic [3:0] min_high,
    input  logic [3:0] min_low,
    input  logic [3:0] sec_high,
    input  logic [3:0] sec_low,
    input  logic [5:0] blink_en,
    input  logic       lz_en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);
    localparam int               c_cnt_w    = $clog2(SCAN_DIV);
    localparam int               c_frm_w    = $clog2(BLINK_FRAMES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_frm_w-1:0] c_frm_max = c_frm_w'(BLINK_FRAMES);
    localparam logic [2:0]       c_idx_last = 3'd5;

    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic               r_phase;
    logic [c_frm_w-1:0] r_frm_cnt;
    logic [5:0][3:0]    r_snap;
    logic [5:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_frame_start;

    logic               w_tick;
    logic               w_wrap;
    logic [2:0]         w_idx_next;
    logic [5:0][3:0]    w_live;
    logic [5:0][3:0]    w_snap_next;
    logic               w_phase_next;
    logic [3:0]         w_digit;
    logic               w_blank;
    logic [5:0]         w_an_next;
    logic [6:0]         w_seg_next;
    logic               w_dp_next;

    function automatic logic [6:0] f_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign w_tick     = (r_cnt == c_cnt_max);
    assign w_wrap     = w_tick && (r_idx == c_idx_last);
    assign w_idx_next = (r_idx == c_idx_last) ? 3'd0 : r_idx + 3'd1;
    assign w_live     = {hour_high, hour_low, min_high, min_low, sec_high, sec_low};
    // Outputs are computed from the post-tick state so they change together with idx.
    assign w_snap_next  = w_wrap ? w_live : r_snap;
    assign w_phase_next = (w_wrap && (r_frm_cnt == c_frm_max)) ? ~r_phase : r_phase;

    always_comb begin
        w_digit = 4'd0;
        case (w_idx_next)
            3'd0:    w_digit = w_snap_next[0];
            3'd1:    w_digit = w_snap_next[1];
            3'd2:    w_digit = w_snap_next[2];
            3'd3:    w_digit = w_snap_next[3];
            3'd4:    w_digit = w_snap_next[4];
            default: w_digit = w_snap_next[5];
        endcase
    end

    assign w_blank = (w_phase_next && blink_en[w_idx_next]) ||
                     ((w_idx_next == c_idx_last) && lz_en && (w_snap_next[5] == 4'd0));

    always_comb begin
        w_an_next  = 6'b111111;
        w_seg_next = 7'b1111111;
        w_dp_next  = 1'b1;
        if (!w_blank) begin
            w_an_next  = ~(6'b000001 << w_idx_next);
            w_seg_next = f_seg(w_digit);
            w_dp_next  = ~((w_idx_next == 3'd2) || (w_idx_next == 3'd4));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= c_idx_last;
            r_phase       <= 1'b0;
            r_frm_cnt     <= '0;
            r_snap        <= '0;
            r_an          <= 6'b111111;
            r_seg         <= 7'b1111111;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            r_cnt         <= w_tick ? '0 : r_cnt + c_cnt_w'(1);
            if (w_tick) begin
                r_idx   <= w_idx_next;
                r_snap  <= w_snap_next;
                r_phase <= w_phase_next;
                r_an    <= w_an_next;
                r_seg   <= w_seg_next;
                r_dp    <= w_dp_next;
            end
            // The first wrap after reset opens frame 0, so the count restarts at 1 on a toggle.
            if (w_wrap) begin
                r_frm_cnt <= (r_frm_cnt == c_frm_max) ? c_frm_w'(1) : r_frm_cnt + c_frm_w'(1);
            end
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_m_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_disp_scan
//  Purpose  : Self-checking bench for m_disp_scan (SCAN_DIV=4, BLINK_FRAMES=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_disp_scan;
    localparam int SD = 4;
    localparam int BF = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [5:0][3:0] digs;
    logic [5:0]      blink_en;
    logic            lz_en;
    logic [5:0]      an;
    logic [6:0]      seg;
    logic            dp;
    logic            frame_start;

    int checks = 0;
    int errors = 0;

    m_disp_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n),
        .hour_high(digs[5]), .hour_low(digs[4]), .min_high(digs[3]),
        .min_low(digs[2]), .sec_high(digs[1]), .sec_low(digs[0]),
        .blink_en(blink_en), .lz_en(lz_en),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] val; logic [6:0] seg; } vec_t;
    vec_t       vecs[16];
    logic [6:0] seg_tab[16];

    // Reference model: edges counted since reset release; tick j lands on edge SD*j.
    int         m_n;
    logic [3:0] m_snap[6];
    logic [5:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp, m_fs;

    task automatic model_reset();
        m_n = 0;
        for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
        m_an = 6'h3F; m_seg = 7'h7F; m_dp = 1'b1; m_fs = 1'b0;
    endtask

    task automatic model_edge();
        int j, idx, frame;
        logic phase, blank;
        m_n++;
        m_fs = 1'b0;
        if (m_n % SD == 0) begin
            j   = m_n / SD;
            idx = (j - 1) % 6;
            if (idx == 0) begin
                for (int i = 0; i < 6; i++) m_snap[i] = digs[i];
                m_fs = 1'b1;
            end
            frame = (j - 1) / 6;
            phase = ((frame / BF) % 2) == 1;
            blank = (phase && blink_en[idx]) || (idx == 5 && lz_en && m_snap[5] == 4'd0);
            if (blank) begin
                m_an = 6'h3F; m_seg = 7'h7F; m_dp = 1'b1;
            end else begin
                m_an  = 6'h3F & ~(6'd1 << idx);
                m_seg = seg_tab[m_snap[idx]];
                m_dp  = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all(input string nm);
        chk({nm, ".an"},  {1'b0, an},          {1'b0, m_an});
        chk({nm, ".seg"}, seg,                 m_seg);
        chk({nm, ".dp"},  {6'd0, dp},          {6'd0, m_dp});
        chk({nm, ".fs"},  {6'd0, frame_start}, {6'd0, m_fs});
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic cycle(input string nm);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all(nm);
    endtask

    task automatic run_until(input string nm, input int target);
        while (m_n < target) cycle(nm);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        chk("reset.an_blank", {1'b0, an}, 7'h3F);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_2359();
        digs[5] = 4'd2; digs[4] = 4'd3; digs[3] = 4'd5;
        digs[2] = 4'd9; digs[1] = 4'd5; digs[0] = 4'd8;
    endtask

    // Explicit 23:59:58 sequence from a fresh release.
    task automatic seq_check();
        logic [5:0] an_e[6];
        logic [6:0] seg_e[6];
        logic       dp_e[6];
        int k;
        an_e  = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
        seg_e = '{7'b0000000, 7'b0010010, 7'b0010000, 7'b0010010, 7'b0110000, 7'b0100100};
        dp_e  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int e = 1; e <= 27; e++) begin
            cycle("seq");
            if (e < 4) begin
                chk("seq.an_idle", {1'b0, an}, 7'h3F);
            end else begin
                k = (e - 4) / 4;
                chk("seq.an",  {1'b0, an}, {1'b0, an_e[k]});
                chk("seq.seg", seg, seg_e[k]);
                chk("seq.dp",  {6'd0, dp}, {6'd0, dp_e[k]});
                chk("seq.fs",  {6'd0, frame_start}, {6'd0, (e == 4)});
            end
        end
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        vecs[0]  = '{4'd0,  7'b1000000}; vecs[1]  = '{4'd1,  7'b1111001};
        vecs[2]  = '{4'd2,  7'b0100100}; vecs[3]  = '{4'd3,  7'b0110000};
        vecs[4]  = '{4'd4,  7'b0011001}; vecs[5]  = '{4'd5,  7'b0010010};
        vecs[6]  = '{4'd6,  7'b0000010}; vecs[7]  = '{4'd7,  7'b1111000};
        vecs[8]  = '{4'd8,  7'b0000000}; vecs[9]  = '{4'd9,  7'b0010000};
        vecs[10] = '{4'd10, 7'b0111111}; vecs[11] = '{4'd11, 7'b0111111};
        vecs[12] = '{4'd12, 7'b0111111}; vecs[13] = '{4'd13, 7'b0111111};
        vecs[14] = '{4'd14, 7'b0111111}; vecs[15] = '{4'd15, 7'b0111111};

        rst_n = 1'b1; digs = '0; blink_en = '0; lz_en = 1'b0;
        model_reset();
        #1;

        // Segment decode table through digit 0.
        for (int v = 0; v < 16; v++) begin
            digs = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1, vecs[v].val};
            do_reset();
            run_until("tab", 4);
            chk("tab.seg", seg, vecs[v].seg);
            chk("tab.an", {1'b0, an}, 7'b0111110);
        end

        // Reset release and full-frame walk.
        set_2359(); blink_en = '0; lz_en = 1'b0;
        do_reset();
        seq_check();

        // Mid-frame change must not tear the current frame.
        set_2359();
        do_reset();
        run_until("tear", 5);
        digs[0] = 4'd9;
        run_until("tear", 7);
        chk("tear.old", seg, 7'b0000000);
        run_until("tear", 28);
        chk("tear.new", seg, 7'b0010000);

        // Leading-zero suppression and dash on min_low.
        digs = {4'd0, 4'd1, 4'd2, 4'hC, 4'd4, 4'd5}; lz_en = 1'b1;
        do_reset();
        run_until("lz", 12);
        chk("dash.seg", seg, 7'b0111111);
        chk("dash.dp", {6'd0, dp}, 7'd0);
        run_until("lz", 24);
        chk("lz.an", {1'b0, an}, 7'h3F);
        chk("lz.seg", seg, 7'h7F);
        lz_en = 1'b0;
        run_until("lz", 48);
        chk("nolz.seg", seg, 7'b1000000);
        chk("nolz.an", {1'b0, an}, 7'b0011111);

        // Blink on digits 4,5, then reset inside a blank phase.
        set_2359(); blink_en = 6'b110000; lz_en = 1'b0;
        do_reset();
        run_until("blink", 20);
        chk("blink.f0", {1'b0, an}, 7'b0101111);
        run_until("blink", 64);
        chk("blink.f2i3", {1'b0, an}, 7'b0110111);
        run_until("blink", 68);
        chk("blink.f2i4", {1'b0, an}, 7'h3F);
        run_until("blink", 116);
        chk("blink.f4i4", {1'b0, an}, 7'b0101111);
        run_until("blink", 161);
        do_reset();
        seq_check();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) digs[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 150) == 0) blink_en = 6'($urandom);
            if ($urandom_range(0, 150) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 700) == 0) do_reset();
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
